// File: rtl/proc_run_pkg.sv
// Shared types for the processor run/step/breakpoint sequencer.
package proc_run_pkg;

  typedef enum logic [1:0] {
    ST_HALT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STEP  = 2'd2,
    ST_BREAK = 2'd3
  } run_state_t;

  localparam int PC_W = 32;

endpackage

// File: rtl/debounce_sync.sv
// Two-flop synchronizer plus debounce filter for a bouncy board input,
// producing a clean level and one-cycle rise/fall pulses.
module debounce_sync #(
  parameter int DEB_CYCLES = 1000000
) (
  input  logic Clk,
  input  logic Reset,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  // cnt tracks how many consecutive cycles sync[1] has disagreed with level;
  // the flip happens on the DEB_CYCLES-th such cycle.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sync  <= 2'b00;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      rise <= 1'b0;
      fall <= 1'b0;
      if (sync[1] != level) begin
        if (cnt == CNT_LAST) begin
          level <= sync[1];
          rise  <= sync[1];
          fall  <= ~sync[1];
          cnt   <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/proc_run_ctrl.sv
// Run/step/breakpoint sequencer: issues one-cycle proc_en pulses to the
// processor and exports its state and pulse count for the display path.
module proc_run_ctrl
  import proc_run_pkg::*;
#(
  parameter int RUN_DIV    = 50000000,
  parameter int DEB_CYCLES = 1000000,
  parameter int CNT_W      = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             run_sw,
  input  logic             step_btn,
  input  logic             bp_en,
  input  logic [PC_W-1:0]  bp_addr,
  input  logic [PC_W-1:0]  pc_addr,
  output logic             proc_en,
  output logic             halted,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] cycle_count
);

  localparam int TICK_W = $clog2(RUN_DIV);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(RUN_DIV - 1);

  run_state_t        cur_state;
  logic [TICK_W-1:0] tick;
  logic              skip;
  logic              run_level, run_rise, run_fall;
  logic              step_level, step_rise, step_fall;
  logic              fire, bp_hit;
  logic              unused_inputs;

  debounce_sync #(.DEB_CYCLES(DEB_CYCLES)) u_run_deb (
    .Clk   (Clk),
    .Reset (Reset),
    .raw   (run_sw),
    .level (run_level),
    .rise  (run_rise),
    .fall  (run_fall)
  );

  debounce_sync #(.DEB_CYCLES(DEB_CYCLES)) u_step_deb (
    .Clk   (Clk),
    .Reset (Reset),
    .raw   (step_btn),
    .level (step_level),
    .rise  (step_rise),
    .fall  (step_fall)
  );

  assign unused_inputs = ^{run_level, step_level, step_fall};

  assign fire   = (tick == TICK_LAST);
  assign bp_hit = bp_en && (pc_addr == bp_addr);
  assign state  = cur_state;
  assign halted = (cur_state == ST_HALT) || (cur_state == ST_BREAK);

  // skip lets the instruction sitting on the breakpoint execute once after a resume.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cur_state   <= ST_HALT;
      tick        <= '0;
      skip        <= 1'b0;
      proc_en     <= 1'b0;
      cycle_count <= '0;
    end else begin
      proc_en <= 1'b0;
      if (proc_en) cycle_count <= cycle_count + CNT_W'(1);
      case (cur_state)
        ST_HALT: begin
          if (run_rise) begin
            cur_state <= ST_RUN;
            tick      <= '0;
            skip      <= 1'b1;
          end else if (step_rise) begin
            cur_state <= ST_STEP;
            proc_en   <= 1'b1;
          end
        end
        ST_RUN: begin
          if (run_fall) begin
            cur_state <= ST_HALT;
          end else begin
            tick <= fire ? '0 : tick + TICK_W'(1);
            if (fire) begin
              if (bp_hit && !skip) begin
                cur_state <= ST_BREAK;
              end else begin
                proc_en <= 1'b1;
                skip    <= 1'b0;
              end
            end
          end
        end
        ST_STEP: begin
          cur_state <= ST_HALT;
        end
        ST_BREAK: begin
          if (run_rise) begin
            cur_state <= ST_RUN;
            tick      <= '0;
            skip      <= 1'b1;
          end else if (step_rise) begin
            cur_state <= ST_STEP;
            proc_en   <= 1'b1;
          end else if (run_fall) begin
            cur_state <= ST_HALT;
          end
        end
        default: cur_state <= ST_HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_proc_run_ctrl.sv
// Self-checking bench for proc_run_ctrl: directed scenarios with literal
// expectations plus randomized switch activity against a behavioural model.
module tb_proc_run_ctrl;

  localparam int RUN_DIV = 4;
  localparam int DEB     = 3;
  localparam int CNT_W   = 8;
  localparam int S_HALT  = 0;
  localparam int S_RUN   = 1;
  localparam int S_STEP  = 2;
  localparam int S_BREAK = 3;

  logic             Clk = 1'b0;
  logic             Reset = 1'b1;
  logic             run_sw = 1'b0;
  logic             step_btn = 1'b0;
  logic             bp_en = 1'b0;
  logic [31:0]      bp_addr = 32'h0;
  logic [31:0]      pc_addr = 32'h0;
  logic             proc_en;
  logic             halted;
  logic [1:0]       state;
  logic [CNT_W-1:0] cycle_count;

  int n_checks = 0;
  int n_errors = 0;

  proc_run_ctrl #(
    .RUN_DIV    (RUN_DIV),
    .DEB_CYCLES (DEB),
    .CNT_W      (CNT_W)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .run_sw      (run_sw),
    .step_btn    (step_btn),
    .bp_en       (bp_en),
    .bp_addr     (bp_addr),
    .pc_addr     (pc_addr),
    .proc_en     (proc_en),
    .halted      (halted),
    .state       (state),
    .cycle_count (cycle_count)
  );

  // ---------------- clock ----------------
  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Debounce: the level flips once the last DEB synchronized samples (raw
  // values seen two edges earlier) all disagree with it.
  int               m_state;
  bit               m_pen;
  logic [CNT_W-1:0] m_cc;
  int               m_age;
  bit               m_skip;
  bit [DEB:0]       h_run, h_step;
  bit               l_run, l_step;
  bit               r_run, f_run, r_step;

  task automatic model_reset();
    m_state = S_HALT; m_pen = 1'b0; m_cc = '0; m_age = 0; m_skip = 1'b0;
    h_run = '0; h_step = '0; l_run = 1'b0; l_step = 1'b0;
    r_run = 1'b0; f_run = 1'b0; r_step = 1'b0;
  endtask

  task automatic model_step();
    int ns;
    bit npen;
    bit fire;
    bit flip;
    ns   = m_state;
    npen = 1'b0;
    m_cc = m_cc + CNT_W'(m_pen);
    case (m_state)
      S_HALT: begin
        if (r_run) begin ns = S_RUN; m_age = 0; m_skip = 1'b1; end
        else if (r_step) begin ns = S_STEP; npen = 1'b1; end
      end
      S_RUN: begin
        if (f_run) ns = S_HALT;
        else begin
          fire  = ((m_age % RUN_DIV) == RUN_DIV - 1);
          m_age = m_age + 1;
          if (fire) begin
            if (bp_en && pc_addr == bp_addr && !m_skip) ns = S_BREAK;
            else begin npen = 1'b1; m_skip = 1'b0; end
          end
        end
      end
      S_STEP: ns = S_HALT;
      default: begin
        if (r_run) begin ns = S_RUN; m_age = 0; m_skip = 1'b1; end
        else if (r_step) begin ns = S_STEP; npen = 1'b1; end
        else if (f_run) ns = S_HALT;
      end
    endcase
    m_state = ns;
    m_pen   = npen;
    flip  = &(h_run[DEB:1] ^ {DEB{l_run}});
    r_run = flip && !l_run;
    f_run = flip && l_run;
    if (flip) l_run = ~l_run;
    h_run = {h_run[DEB-1:0], run_sw};
    flip   = &(h_step[DEB:1] ^ {DEB{l_step}});
    r_step = flip && !l_step;
    if (flip) l_step = ~l_step;
    h_step = {h_step[DEB-1:0], step_btn};
  endtask

  // ---------------- scoreboard / compare ----------------
  always @(posedge Clk) begin
    if (Reset) model_reset();
    else model_step();
    #1;
    check("state", state, m_state);
    check("proc_en", proc_en, m_pen);
    check("halted", halted, (m_state == S_HALT || m_state == S_BREAK));
    check("cycle_count", cycle_count, m_cc);
  end

  // ---------------- driver ----------------
  // One cycle at a time on the falling edge; the processor stand-in advances
  // its PC by 4 for each enable pulse.
  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge Clk);
      if (proc_en) pc_addr = pc_addr + 32'd4;
    end
  endtask

  int np, first, second, pidx, t;

  initial begin
    // reset and idle
    Reset = 1'b1;
    cyc(3);
    Reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      check("idle_state", state, S_HALT);
      check("idle_halted", halted, 1'b1);
      check("idle_proc_en", proc_en, 1'b0);
      check("idle_count", cycle_count, 0);
    end

    // bouncy step press: glitches must not trigger, the stable press gives one pulse
    step_btn = 1'b1; cyc(1); step_btn = 1'b0; cyc(1);
    step_btn = 1'b1; cyc(1); step_btn = 1'b0; cyc(1);
    step_btn = 1'b1;
    np = 0; pidx = 0;
    for (int i = 1; i <= 10; i++) begin
      cyc(1);
      if (proc_en) begin
        np++; pidx = i;
        check("step_pulse_state", state, S_STEP);
      end
    end
    // first sampling edge is edge 1; pulse lands 5 edges later
    check("step_pulse_count", np, 1);
    check("step_pulse_pos", pidx, 6);
    check("step_back_halt", state, S_HALT);
    check("step_cycle_count", cycle_count, 1);
    step_btn = 1'b0;
    cyc(10);

    // free run without breakpoint
    pc_addr = 32'h0;
    run_sw = 1'b1;
    np = 0; first = 0; second = 0;
    for (int i = 1; i <= 47; i++) begin
      cyc(1);
      if (i == 6) check("run_entry_state", state, S_RUN);
      if (proc_en) begin
        np++;
        if (np == 1) first = i;
        if (np == 2) second = i;
      end
    end
    check("run_first_pulse", first, 10);
    check("run_pulse_gap", second - first, RUN_DIV);
    check("run_pulse_num", np, 10);
    // one earlier step plus ten run pulses
    check("run_cycle_count", cycle_count, 11);
    run_sw = 1'b0;
    cyc(10);
    check("run_stop_state", state, S_HALT);

    // breakpoint at 0xC
    bp_en = 1'b1; bp_addr = 32'hC; pc_addr = 32'h0;
    run_sw = 1'b1;
    for (t = 1; t <= 60; t++) begin
      cyc(1);
      if (state == S_BREAK) break;
    end
    check("bp_trap_time", t, 22);
    check("bp_trap_pc", pc_addr, 32'hC);
    check("bp_trap_no_pulse", proc_en, 1'b0);
    check("bp_trap_halted", halted, 1'b1);

    // resume: the breakpoint instruction runs, then the next breakpoint traps
    run_sw = 1'b0;
    cyc(8);
    check("bp_resume_halt", state, S_HALT);
    run_sw = 1'b1;
    for (t = 1; t <= 30; t++) begin
      cyc(1);
      if (pc_addr != 32'hC) break;
    end
    check("bp_resume_time", t, 10);
    check("bp_resume_pc", pc_addr, 32'h10);
    bp_addr = 32'h14;
    for (t = 1; t <= 30; t++) begin
      cyc(1);
      if (state == S_BREAK) break;
    end
    check("bp_retrap_time", t, 8);
    check("bp_retrap_pc", pc_addr, 32'h14);

    // run fall arriving on a fire cycle suppresses that pulse
    run_sw = 1'b0;
    cyc(8);
    bp_en = 1'b0;
    run_sw = 1'b1;
    for (t = 1; t <= 40; t++) begin
      cyc(1);
      if (m_state == S_RUN && (m_age % RUN_DIV) == 2) break;
    end
    check("fall_setup_found", (t <= 40), 1'b1);
    run_sw = 1'b0;
    np = 0;
    for (int i = 1; i <= 8; i++) begin
      cyc(1);
      if (proc_en) np++;
    end
    check("fall_fire_pulses", np, 1);
    check("fall_fire_state", state, S_HALT);

    // simultaneous run and step rises: run wins
    run_sw = 1'b1; step_btn = 1'b1;
    np = 0;
    for (int i = 1; i <= 8; i++) begin
      cyc(1);
      if (i == 6) check("both_rise_state", state, S_RUN);
      if (proc_en) np++;
    end
    check("both_rise_no_step", np, 0);
    step_btn = 1'b0;

    // reset in the middle of a pulse
    for (t = 1; t <= 20; t++) begin
      cyc(1);
      if (proc_en) break;
    end
    check("rst_pulse_found", proc_en, 1'b1);
    Reset = 1'b1;
    #1;
    check("rst_proc_en", proc_en, 1'b0);
    check("rst_state", state, S_HALT);
    check("rst_count", cycle_count, 0);
    check("rst_halted", halted, 1'b1);
    run_sw = 1'b0;
    cyc(3);
    Reset = 1'b0;
    cyc(5);
    check("rst_after_state", state, S_HALT);

    // randomized switch activity
    pc_addr = 32'h0;
    for (int seg = 0; seg < 250; seg++) begin
      if ($urandom_range(0, 2) == 0) run_sw = ~run_sw;
      if ($urandom_range(0, 1) == 0) step_btn = ~step_btn;
      bp_en   = 1'($urandom_range(0, 1));
      bp_addr = 32'($urandom_range(0, 12)) << 2;
      if (pc_addr > 32'h40) pc_addr = 32'h0;
      cyc(int'($urandom_range(1, 14)));
    end

    // long run to wrap the pulse counter
    step_btn = 1'b0; bp_en = 1'b0; run_sw = 1'b0;
    cyc(10);
    run_sw = 1'b1;
    cyc(1200);
    run_sw = 1'b0;
    cyc(20);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/proc_run_ctrl.md
Name: proc_run_ctrl

Overview:
- Run/step/breakpoint sequencer for the single-cycle/pipelined processor on the board.
- Produces a one-cycle clock-enable pulse, `proc_en`, to the processor and lets the operator choose between:
  - free-running at a divided rate,
  - single-stepping one instruction per button press,
  - halting automatically on a PC breakpoint.
- Sits between the board switches/buttons and the processor enable.
- `state` and `cycle_count` are exported for the seven-segment display path.

Parameters:
- RUN_DIV, 50000000, Clk cycles between `proc_en` pulses in RUN (≥2).
- DEB_CYCLES, 1000000, consecutive stable cycles needed to accept a new debounced level (≥1).
- CNT_W, 32, width of `cycle_count`.

Ports:
- Clk  input  1  system clock; all logic on rising edge.
- Reset  input  1  asynchronous, active-high reset.
- run_sw  input  1  raw run switch (asynchronous to Clk, bouncy).
- step_btn  input  1  raw step push-button (asynchronous, bouncy).
- bp_en  input  1  breakpoint enable (static switch, sampled directly).
- bp_addr  input  32  breakpoint PC value.
- pc_addr  input  32  current PC from processor.
- proc_en  output  1  one-Clk-cycle enable to processor; one pulse = one instruction advance.
- halted  output  1  high in HALT or BREAK.
- state  output  2  current state encoding.
- cycle_count  output  CNT_W  number of `proc_en` pulses issued.

Behaviour:
- Reset (async, active-high). While asserted and on release:
  - state=HALT(0), proc_en=0, halted=1, cycle_count=0;
  - tick counter=0, skip flag=0;
  - synchronizers and debounced levels=0.
- Input conditioning (`run_sw`, `step_btn` each):
  - 2-flop synchronizer, then debounce counter.
  - The debounced level changes only after the synchronized input differs from it for DEB_CYCLES consecutive cycles; any mismatch-free cycle resets the counter.
  - Rising/falling edge pulses are one cycle wide, taken from the debounced level.
  - Latency from raw change to edge pulse is 2+DEB_CYCLES cycles.
- State encodings: HALT=0, RUN=1, STEP=2, BREAK=3.
- HALT:
  - run rise → RUN, with tick counter cleared and skip=1.
  - Otherwise step rise → STEP.
  - Run rise has priority over a simultaneous step rise.
- RUN:
  - Tick counter counts 0..RUN_DIV-1, then wraps to 0.
  - The fire cycle is the one where counter==RUN_DIV-1.
  - In a fire cycle:
    - if bp_en && pc_addr==bp_addr && !skip → BREAK, no pulse;
    - otherwise proc_en=1 and skip clears.
  - run fall → HALT immediately. A fire in that same cycle is suppressed.
  - Step rises are ignored in RUN.
- STEP:
  - proc_en=1 for exactly this one cycle, then unconditionally → HALT.
  - Step does not check the breakpoint.
- BREAK:
  - run rise → RUN, with skip=1 so the breakpoint instruction executes.
  - step rise → STEP. Run has priority.
  - run fall → HALT.
- proc_en is registered and high for at most one consecutive cycle. Two pulses are never closer than 2 cycles apart.
- cycle_count increments on every cycle with proc_en=1 and wraps modulo 2^CNT_W.
- `halted` = (state==HALT)||(state==BREAK).
- Reset asserted mid-pulse clears proc_en in the same instant; no partial pulse persists after reset release.
- pc_addr/bp_addr are compared combinationally each fire cycle, full 32 bits, unsigned equality.

Decomposition:
- Package `proc_run_pkg`:
  - state encodings HALT/RUN/STEP/BREAK (2-bit);
  - a 2-bit state typedef.
- One sub-module `debounce_sync`:
  - parameter DEB_CYCLES;
  - ports Clk, Reset, raw in → level, rise, fall;
  - instantiated twice (`run_sw`, `step_btn`).
- The tick counter, skip flag and FSM live in the top.

Test Plan (bench parameters RUN_DIV=4, DEB_CYCLES=3):
- Reset release, inputs 0 → state=0, halted=1, proc_en=0, cycle_count=0 for 20 cycles.
- step_btn high with 2 bounces (1-cycle glitches) then stable 10 cycles → exactly one proc_en pulse, 5 cycles after the stable level began; state HALT→STEP→HALT; cycle_count=1.
- run_sw stable high, bp_en=0 → proc_en every 4th cycle, first pulse 4 cycles after RUN entry; after 40 cycles in RUN cycle_count=10.
- bp_en=1, bp_addr=0x0000000C, pc_addr model advances by 4 per pulse from 0 → pulses at PC 0,4,8; at the fire cycle with PC=0xC, state→BREAK, no pulse, halted=1. Then:
  - toggle run_sw low/high → RUN, the PC=0xC fire pulses (skip);
  - the next breakpoint hit traps again.
- In RUN, drop run_sw on a debounced fall coinciding with a fire cycle → no pulse, state=HALT.
- Simultaneous debounced run and step rises in HALT → RUN entered, no STEP pulse.
- Assert Reset in the cycle proc_en=1 during RUN → proc_en=0 immediately, state=HALT, cycle_count=0.
